// File: rtl/hyperbus_cfg_arbiter.sv
// Round-robin arbiter sharing the HyperBus config register port between NumReq requesters.
// Optional stall abort: define HYPERBUS_CFG_ARB_TIMEOUT_EN.
package hyperbus_cfg_arbiter_pkg;
  typedef struct packed {
    logic [3:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module hyperbus_cfg_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned RegAddrWidth  = 4,
  parameter int unsigned RegDataWidth  = 32,
  parameter type         reg_req_t     = hyperbus_cfg_arbiter_pkg::reg_req_t,
  parameter type         reg_rsp_t     = hyperbus_cfg_arbiter_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW         = $clog2(NumReq)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  reg_req_t        req_i [NumReq],
  output reg_rsp_t        rsp_o [NumReq],
  output reg_req_t        reg_req_o,
  input  reg_rsp_t        reg_rsp_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            busy_o,
  output logic            timeout_o
);

  if (NumReq < 2 || RegDataWidth < 16 || TimeoutCycles < 2 ||
      $bits(reg_rsp_t) != RegDataWidth + 2 ||
      $bits(reg_req_t) != RegAddrWidth + RegDataWidth + RegDataWidth / 8 + 2) begin : g_bad_cfg
    $error("hyperbus_cfg_arbiter: bad parameters");
  end

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  reg_req_t        hold_q, hold_d;
  logic            pick_vld;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] cand;
  logic            busy;
  logic            abort;
  logic            done;

  assign busy = (state_q == StBusy);

  // First valid requester at or after rr_q, wrapping cyclically.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned o = 0; o < NumReq; o++) begin
      if (32'(rr_q) + o >= NumReq) cand = IdxW'(32'(rr_q) + o - NumReq);
      else cand = IdxW'(32'(rr_q) + o);
      if (!pick_vld && req_i[cand].valid) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign abort = busy && !reg_rsp_i.ready &&
                 (cnt_q == 16'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy) cnt_d = '0;
    else if (!reg_rsp_i.ready) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  assign done = busy && (reg_rsp_i.ready || abort);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    if (!busy) begin
      if (pick_vld) begin
        state_d      = StBusy;
        gnt_d        = pick_idx;
        hold_d       = req_i[pick_idx];
        hold_d.valid = 1'b0;
      end
    end else if (done) begin
      state_d = StIdle;
      if (32'(gnt_q) == NumReq - 1) rr_d = '0;
      else rr_d = gnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      rsp_o[k] = '0;
      if (busy && gnt_q == IdxW'(k)) begin
        if (reg_rsp_i.ready) begin
          rsp_o[k].rdata = reg_rsp_i.rdata;
          rsp_o[k].error = reg_rsp_i.error;
          rsp_o[k].ready = 1'b1;
        end else if (abort) begin
          rsp_o[k].error = 1'b1;
          rsp_o[k].ready = 1'b1;
        end
      end
    end
  end

  always_comb begin
    reg_req_o       = hold_q;
    reg_req_o.valid = busy;
  end

  assign gnt_idx_o = gnt_q;
  assign busy_o    = busy;
  assign timeout_o = abort;

endmodule

// File: tb/tb_hyperbus_cfg_arbiter.sv
// Randomised and directed bench for hyperbus_cfg_arbiter (NumReq=3, TimeoutCycles=8).
// Reference is a transaction-level model of the round-robin arbiter.
module tb_hyperbus_cfg_arbiter;
  import hyperbus_cfg_arbiter_pkg::*;

  localparam int N = 3;
  localparam int TO = 8;

  logic     clk = 1'b0;
  logic     rst;
  reg_req_t req [N];
  reg_rsp_t rsp [N];
  reg_req_t dreq;
  reg_rsp_t drsp;
  logic [1:0] gnt;
  logic     busy, tmo;

  always #5 clk = ~clk;

  hyperbus_cfg_arbiter #(
    .NumReq       (N),
    .RegAddrWidth (4),
    .RegDataWidth (32),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .rsp_o    (rsp),
    .reg_req_o(dreq),
    .reg_rsp_i(drsp),
    .gnt_idx_o(gnt),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // reference model: transaction in flight, owner, next-priority slot
  bit       m_busy;
  int       m_gnt, m_ptr, m_wait;
  reg_req_t m_req;

  int  resp_n, last_k, last_err;
  logic [31:0] last_rdata;
  int  tmo_n;
  bit  prev_busy;
  int  grants [$];

  function automatic reg_rsp_t exp_rsp(int k);
    reg_rsp_t r;
    r = '0;
    if (m_busy && k == m_gnt) begin
      if (drsp.ready) begin
        r.rdata = drsp.rdata;
        r.error = drsp.error;
        r.ready = 1'b1;
      end
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
      else if (m_wait == TO - 1) begin
        r.error = 1'b1;
        r.ready = 1'b1;
      end
`endif
    end
    return r;
  endfunction

  task automatic tick();
    bit to_now;
    bit found;
    int k;
    #1;
    to_now = 1'b0;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
    to_now = m_busy && !drsp.ready && m_wait == TO - 1;
`endif
    check("busy", 64'(busy), 64'(m_busy));
    check("gnt", 64'(gnt), 64'(m_gnt));
    check("dvalid", 64'(dreq.valid), 64'(m_busy));
    if (m_busy) begin
      check("dreq", 64'(dreq), 64'({m_req.addr, m_req.write,
            m_req.wdata, m_req.wstrb, 1'b1}));
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rsp%0d", i), 64'(rsp[i]), 64'(exp_rsp(i)));
      if (rsp[i].ready === 1'b1) begin
        resp_n++;
        last_k = i;
        last_err = int'(rsp[i].error);
        last_rdata = rsp[i].rdata;
      end
    end
    check("timeout", 64'(tmo), 64'(to_now));
    if (tmo === 1'b1) tmo_n++;
    if (busy === 1'b1 && !prev_busy) grants.push_back(int'(gnt));
    prev_busy = (busy === 1'b1);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_gnt = 0; m_ptr = 0; m_wait = 0;
      m_req = '0;
    end else if (!m_busy) begin
      found = 0;
      for (int o = 0; o < N; o++) begin
        k = (m_ptr + o) % N;
        if (!found && req[k].valid) begin
          found = 1;
          m_gnt = k;
          m_req = req[k];
          m_busy = 1;
          m_wait = 0;
        end
      end
    end else if (drsp.ready || to_now) begin
      m_busy = 0;
      m_ptr = (m_gnt + 1) % N;
    end else begin
      m_wait++;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    for (int i = 0; i < N; i++) req[i] = '0;
    drsp = '0;
    drsp.ready = 1'b1;
  endtask

  initial begin
    m_busy = 0; m_gnt = 0; m_ptr = 0; m_wait = 0; m_req = '0;
    resp_n = 0; last_k = -1; last_err = -1; last_rdata = '0;
    tmo_n = 0; prev_busy = 0;
    quiet();
    // T1 reset with requester 0 pending
    rst = 1'b1;
    req[0].valid = 1'b1;
    req[0].addr = 4'h2;
    @(posedge clk);
    @(negedge clk);
    tick();
    tick();
    #1;
    check("t1_dreq_zero", 64'(dreq), 64'd0);
    check("t1_gnt_zero", 64'(gnt), 64'd0);
    rst = 1'b0;
    tick();
    #1;
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_ready0", 64'(rsp[0].ready), 64'd1);
    tick();
    quiet();
    tick();

    // T2 single write from requester 1
    req[1].valid = 1'b1;
    req[1].write = 1'b1;
    req[1].addr = 4'h8;
    req[1].wdata = 32'h0000_015E;
    req[1].wstrb = 4'hF;
    tick();
    #1;
    check("t2_gnt", 64'(gnt), 64'd1);
    check("t2_wdata", 64'(dreq.wdata), 64'h15E);
    check("t2_addr", 64'(dreq.addr), 64'h8);
    check("t2_ready1", 64'(rsp[1].ready), 64'd1);
    tick();
    quiet();
    tick();

    // T3 fairness from a fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grants.delete();
    for (int i = 0; i < N; i++) req[i].valid = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    check("t3_ngrants", 64'(grants.size()), 64'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("t3_order%0d", i), 64'(grants[i]), 64'(i % N));
    quiet();
    tick();
    tick();

    // T4 stalled read on requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_n = 0;
    req[0].valid = 1'b1;
    req[0].addr = 4'h0;
    drsp.ready = 1'b0;
    tick();
    for (int c = 0; c < 10; c++) tick();
    drsp.ready = 1'b1;
    drsp.rdata = 32'h6;
    tick();
    req[0].valid = 1'b0;
`ifndef HYPERBUS_CFG_ARB_TIMEOUT_EN
    check("t4_nresp", 64'(resp_n), 64'd1);
    check("t4_rdata", 64'(last_rdata), 64'h6);
    check("t4_err", 64'(last_err), 64'd0);
`endif
    quiet();
    tick();

    // T5 downstream error is forwarded
    resp_n = 0;
    req[2].valid = 1'b1;
    req[2].addr = 4'hC;
    drsp.error = 1'b1;
    tick();
    tick();
    req[2].valid = 1'b0;
    check("t5_nresp", 64'(resp_n), 64'd1);
    check("t5_k", 64'(last_k), 64'd2);
    check("t5_err", 64'(last_err), 64'd1);
    quiet();
    tick();

    // T6 downstream never ready
    resp_n = 0;
    tmo_n = 0;
    req[0].valid = 1'b1;
    drsp.ready = 1'b0;
    for (int c = 0; c < 100; c++) tick();
    req[0].valid = 1'b0;
`ifdef HYPERBUS_CFG_ARB_TIMEOUT_EN
    check("t6_tmo", 64'(tmo_n), 64'd11);
`else
    check("t6_nresp", 64'(resp_n), 64'd0);
    check("t6_tmo", 64'(tmo_n), 64'd0);
`endif
    quiet();
    tick();
    tick();

    // randomised traffic with occasional reset
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        req[i].valid = ($urandom_range(0, 2) != 0);
        req[i].write = 1'($urandom);
        req[i].addr = 4'($urandom);
        req[i].wdata = $urandom;
        req[i].wstrb = 4'($urandom);
      end
      drsp.ready = ($urandom_range(0, 3) == 0);
      drsp.error = 1'($urandom);
      drsp.rdata = $urandom;
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
